data_memory_hs: RTL

Parametrised, byte-addressed data memory with a request/response handshake, configurable access latency, byte/word access sizes with sign or zero extension, and alignment/range error reporting. Serves the multi-cycle datapath's memory stage as the next-generation data memory: the controller issues one access at a time and waits for `Valid` instead of relying on fixed clock-edge timing.

---
 rtl/data_memory_hs.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_hs.sv
// Byte-addressed data memory behind a single-outstanding request/response handshake.
// Accesses take LATENCY busy cycles, then a one-cycle Valid/Error response.
module data_memory_hs #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 2,
    // Name of a byte-per-line hex image; the memory preload flow reads it.
    parameter     INIT_FILE = ""
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Write,
    input  logic              Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Ready,
    output logic              Valid,
    output logic              Error,
    output logic [DATA_W-1:0] ReadData,
    output logic [1:0]        fsm_state
);

    // Handshake: a request is taken on any rising edge where Req=1 and Ready=1;
    // Req is ignored while Ready=0. Each accepted request yields exactly one
    // Valid pulse (with Error qualifying it) before Ready rises again.

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   SPAN     = (ADDR_W+1)'(BPW - 1);
    localparam logic [ADDR_W-1:0] BPW_A    = ADDR_W'(BPW);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;

    logic              is_word;
    logic [ADDR_W:0]   last_byte;
    logic              access_err;
    logic              access_now;
    logic              do_write;
    logic [DATA_W-1:0] load_val;

    logic [7:0] mem [DEPTH];

    function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_W-1:0] a, input int k);
        return IDX_W'(a + ADDR_W'(k));
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Req) state_next = S_BUSY;
            S_BUSY:  if (cnt == '0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign Ready     = (state == S_IDLE);
    assign fsm_state = state;

    // ---------------- access decode ----------------
    always_comb begin
        is_word    = (BPW > 1) && size_q;
        last_byte  = {1'b0, addr_q} + (is_word ? SPAN : '0);
        access_err = (last_byte >= DEPTH_L) ||
                     (is_word && ((addr_q % BPW_A) != '0));
        access_now = (state == S_BUSY) && (cnt == '0);
        do_write   = access_now && write_q && !access_err;
    end

    // Byte loads build the extension first, then overlay the low byte.
    always_comb begin
        load_val = '0;
        if (is_word) begin
            for (int k = 0; k < BPW; k++) begin
                load_val[8*k +: 8] = mem[byte_idx(addr_q, k)];
            end
        end else begin
            load_val      = {DATA_W{signed_q & mem[byte_idx(addr_q, 0)][7]}};
            load_val[7:0] = mem[byte_idx(addr_q, 0)];
        end
    end

    // ---------------- request capture and response ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            Valid    <= 1'b0;
            Error    <= 1'b0;
            ReadData <= '0;
        end else begin
            Valid <= 1'b0;
            Error <= 1'b0;
            if ((state == S_IDLE) && Req) begin
                cnt      <= CNT_INIT;
                addr_q   <= Address;
                write_q  <= Write;
                size_q   <= Size;
                signed_q <= Signed;
                wdata_q  <= WriteData;
            end else if ((state == S_BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (access_now) begin
                Valid <= 1'b1;
                Error <= access_err;
                if (access_err) begin
                    ReadData <= '0;
                end else if (!write_q) begin
                    ReadData <= load_val;
                end
            end
        end
    end

    // Array has no reset so contents survive Reset; an access aborted by
    // Reset never reaches this edge in BUSY.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            if (is_word) begin
                for (int k = 0; k < BPW; k++) begin
                    mem[byte_idx(addr_q, k)] <= wdata_q[8*k +: 8];
                end
            end else begin
                mem[byte_idx(addr_q, 0)] <= wdata_q[7:0];
            end
        end
    end

endmodule
